// File: rtl/mdio_sched_if.sv
// Bundle of signals between the MDIO scheduler, its CPU client, the MDIO master and the link poller.
// The slave modport is the scheduler's view; the master modport is the surrounding system's view.
interface mdio_sched_if;
    logic        cpu_req_valid;
    logic        cpu_req_write;
    logic [4:0]  cpu_req_phy;
    logic [4:0]  cpu_req_reg;
    logic [15:0] cpu_req_wdata;
    logic        cpu_req_ready;
    logic [15:0] cpu_rsp_rdata;
    logic        cpu_rsp_err;
    logic        mdio_start;
    logic        mdio_write;
    logic [4:0]  mdio_phy;
    logic [4:0]  mdio_reg;
    logic [15:0] mdio_wdata;
    logic        mdio_busy;
    logic [15:0] mdio_rdata;
    logic        poll_en;
    logic        irq_clr;
    logic        link_up;
    logic [15:0] link_status;
    logic        link_chg;

    modport slave (
        input  cpu_req_valid, cpu_req_write, cpu_req_phy, cpu_req_reg, cpu_req_wdata,
        output cpu_req_ready, cpu_rsp_rdata, cpu_rsp_err,
        output mdio_start, mdio_write, mdio_phy, mdio_reg, mdio_wdata,
        input  mdio_busy, mdio_rdata,
        input  poll_en, irq_clr,
        output link_up, link_status, link_chg
    );

    modport master (
        output cpu_req_valid, cpu_req_write, cpu_req_phy, cpu_req_reg, cpu_req_wdata,
        input  cpu_req_ready, cpu_rsp_rdata, cpu_rsp_err,
        input  mdio_start, mdio_write, mdio_phy, mdio_reg, mdio_wdata,
        output mdio_busy, mdio_rdata,
        output poll_en, irq_clr,
        input  link_up, link_status, link_chg
    );
endinterface

// File: rtl/mdio_sched.sv
// Shares one MDIO master between CPU register accesses and a periodic PHY link-status poller,
// sequencing the start/busy handshake with per-phase timeouts and publishing link state.
module mdio_sched #(
    parameter logic [23:0] POLL_DIV = 24'd12_500_000,
    parameter logic [4:0]  PHY_ID   = 5'd0,
    parameter logic [4:0]  STAT_REG = 5'd1,
    parameter int unsigned LINK_BIT = 2,
    parameter logic [19:0] TIMEOUT  = 20'd32768
) (
    input  logic         clk,
    input  logic         arst_n,
    mdio_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [19:0] TMO_LAST  = TIMEOUT - 20'd1;
    localparam logic [23:0] POLL_LAST = POLL_DIV - 24'd1;

    state_t      state_r;
    state_t      state_next_s;
    logic        busy_meta_r;
    logic        busy_sync_r;
    logic [19:0] tmo_cnt_r;
    logic        tmo_hit_s;
    logic [23:0] poll_cnt_r;
    logic        poll_term_s;
    logic        poll_pending_r;
    logic        last_poll_r;
    logic        grant_cpu_r;
    logic        err_r;
    logic [15:0] rdata_cap_r;
    logic        cpu_want_s;
    logic        take_cpu_s;
    logic        take_poll_s;
    logic        mdio_start_r;
    logic        mdio_write_r;
    logic [4:0]  mdio_phy_r;
    logic [4:0]  mdio_reg_r;
    logic [15:0] mdio_wdata_r;
    logic        cpu_req_ready_r;
    logic [15:0] cpu_rsp_rdata_r;
    logic        cpu_rsp_err_r;
    logic        link_up_r;
    logic [15:0] link_status_r;
    logic        link_chg_r;
    logic        poll_done_s;
    logic        link_new_s;
    logic        link_set_s;

    // A request still visible during its own ready pulse must not be granted a second time.
    assign cpu_want_s  = bus.cpu_req_valid & ~cpu_req_ready_r;
    assign tmo_hit_s   = (tmo_cnt_r == TMO_LAST);
    assign poll_term_s = (poll_cnt_r == POLL_LAST);
    assign poll_done_s = (state_r == ST_DONE) && !grant_cpu_r;
    assign link_new_s  = err_r ? 1'b0 : rdata_cap_r[LINK_BIT];
    assign link_set_s  = poll_done_s && (link_new_s != link_up_r);

    // Next-state and arbitration decision.
    always_comb begin
        state_next_s = state_r;
        take_cpu_s   = 1'b0;
        take_poll_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_want_s && poll_pending_r) begin
                    if (last_poll_r) begin
                        take_cpu_s = 1'b1;
                    end else begin
                        take_poll_s = 1'b1;
                    end
                end else if (cpu_want_s) begin
                    take_cpu_s = 1'b1;
                end else if (poll_pending_r) begin
                    take_poll_s = 1'b1;
                end else begin
                    take_cpu_s = 1'b0;
                end
                if (take_cpu_s || take_poll_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (busy_sync_r) begin
                    state_next_s = ST_WAIT;
                end else if (tmo_hit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_WAIT: begin
                if (!busy_sync_r) begin
                    state_next_s = ST_DONE;
                end else if (tmo_hit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Two-flop synchroniser for the master's busy flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_meta_r <= 1'b0;
            busy_sync_r <= 1'b0;
        end else begin
            busy_meta_r <= bus.mdio_busy;
            busy_sync_r <= busy_meta_r;
        end
    end

    // State register and per-phase timeout counter, restarted on every phase change.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= 20'd0;
        end else begin
            state_r <= state_next_s;
            if ((state_next_s != state_r) || (state_r == ST_IDLE) || (state_r == ST_DONE)) begin
                tmo_cnt_r <= 20'd0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + 20'd1;
            end
        end
    end

    // Transaction launch, handshake and result capture.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mdio_start_r <= 1'b0;
            mdio_write_r <= 1'b0;
            mdio_phy_r   <= 5'd0;
            mdio_reg_r   <= 5'd0;
            mdio_wdata_r <= 16'd0;
            grant_cpu_r  <= 1'b0;
            last_poll_r  <= 1'b1;
            err_r        <= 1'b0;
            rdata_cap_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (take_cpu_s || take_poll_s) begin
                        mdio_start_r <= 1'b1;
                        mdio_write_r <= take_cpu_s & bus.cpu_req_write;
                        mdio_phy_r   <= take_cpu_s ? bus.cpu_req_phy : PHY_ID;
                        mdio_reg_r   <= take_cpu_s ? bus.cpu_req_reg : STAT_REG;
                        mdio_wdata_r <= take_cpu_s ? bus.cpu_req_wdata : 16'd0;
                        grant_cpu_r  <= take_cpu_s;
                        last_poll_r  <= take_poll_s;
                        err_r        <= 1'b0;
                    end
                end
                ST_START: begin
                    if (busy_sync_r) begin
                        mdio_start_r <= 1'b0;
                    end else if (tmo_hit_s) begin
                        mdio_start_r <= 1'b0;
                        err_r        <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!busy_sync_r) begin
                        rdata_cap_r <= bus.mdio_rdata;
                    end else if (tmo_hit_s) begin
                        err_r <= 1'b1;
                    end
                end
                default: begin
                    mdio_start_r <= mdio_start_r;
                end
            endcase
        end
    end

    // CPU completion pulse with registered response.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cpu_req_ready_r <= 1'b0;
            cpu_rsp_rdata_r <= 16'd0;
            cpu_rsp_err_r   <= 1'b0;
        end else begin
            cpu_req_ready_r <= (state_r == ST_DONE) && grant_cpu_r;
            if ((state_r == ST_DONE) && grant_cpu_r) begin
                cpu_rsp_err_r   <= err_r;
                cpu_rsp_rdata_r <= err_r ? 16'hFFFF : (mdio_write_r ? 16'd0 : rdata_cap_r);
            end
        end
    end

    // Poll interval timer; a due poll stays pending until granted, without queueing.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            poll_cnt_r     <= 24'd0;
            poll_pending_r <= 1'b0;
        end else if (!bus.poll_en) begin
            poll_cnt_r     <= 24'd0;
            poll_pending_r <= 1'b0;
        end else begin
            poll_cnt_r <= poll_term_s ? 24'd0 : (poll_cnt_r + 24'd1);
            if (poll_term_s) begin
                poll_pending_r <= 1'b1;
            end else if (take_poll_s) begin
                poll_pending_r <= 1'b0;
            end
        end
    end

    // Published link state; a change event takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            link_up_r     <= 1'b0;
            link_status_r <= 16'd0;
            link_chg_r    <= 1'b0;
        end else begin
            if (poll_done_s) begin
                link_up_r <= link_new_s;
                if (!err_r) begin
                    link_status_r <= rdata_cap_r;
                end
            end
            if (link_set_s) begin
                link_chg_r <= 1'b1;
            end else if (bus.irq_clr) begin
                link_chg_r <= 1'b0;
            end
        end
    end

    assign bus.cpu_req_ready = cpu_req_ready_r;
    assign bus.cpu_rsp_rdata = cpu_rsp_rdata_r;
    assign bus.cpu_rsp_err   = cpu_rsp_err_r;
    assign bus.mdio_start    = mdio_start_r;
    assign bus.mdio_write    = mdio_write_r;
    assign bus.mdio_phy      = mdio_phy_r;
    assign bus.mdio_reg      = mdio_reg_r;
    assign bus.mdio_wdata    = mdio_wdata_r;
    assign bus.link_up       = link_up_r;
    assign bus.link_status   = link_status_r;
    assign bus.link_chg      = link_chg_r;
endmodule

// File: tb/tb_mdio_sched.sv
// Self-checking bench for mdio_sched: a behavioural PHY register file answers the MDIO handshake,
// CPU traffic is checked against a reference register map, and poll results against the PHY status.
module tb_mdio_sched;
    localparam int POLL_T = 64;
    localparam int TMO_T  = 50;
    localparam logic [9:0] STAT_ADDR = 10'd1;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    mdio_sched_if bus();

    mdio_sched #(
        .POLL_DIV (24'd64),
        .PHY_ID   (5'd0),
        .STAT_REG (5'd1),
        .LINK_BIT (2),
        .TIMEOUT  (20'd50)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // PHY device model controls
    logic        slave_rst;
    logic        no_busy;
    int          sl_dly;
    int          sl_len;
    logic [15:0] stat_val;
    logic [15:0] phy_mem [0:1023];
    int          sl_st = 0;
    int          sl_cnt = 0;
    logic        sl_wr = 1'b0;
    logic [9:0]  sl_addr = 10'd0;
    logic [15:0] sl_wd = 16'd0;

    // Bus monitor state
    int   cyc = 0;
    logic start_prev = 1'b0;
    int   start_cnt = 0;
    int   start_run = 0;
    int   last_start_len = 0;
    int   poll_start_cnt = 0;
    int   last_poll_cyc = 0;
    int   poll_period = 0;
    logic ready_prev = 1'b0;
    int   ready_cnt = 0;
    int   ready_dbl = 0;
    bit   grant_q [$];

    // Reference register map of CPU-visible PHY registers
    logic [15:0] ref_mem [int];
    int          wr_addrs [$];
    int          cpu_n = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {bus.cpu_req_ready, bus.cpu_rsp_rdata, bus.cpu_rsp_err, bus.mdio_start,
                bus.mdio_write, bus.mdio_phy, bus.mdio_reg, bus.mdio_wdata,
                bus.link_up, bus.link_status, bus.link_chg};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // PHY side of the handshake: raise busy after sl_dly, hold it sl_len cycles, then return data.
    always @(negedge clk) begin
        if (slave_rst) begin
            sl_st <= 0;
            bus.mdio_busy  <= 1'b0;
            bus.mdio_rdata <= 16'd0;
        end else begin
            case (sl_st)
                0: if (bus.mdio_start && !no_busy) begin
                    sl_wr   <= bus.mdio_write;
                    sl_addr <= {bus.mdio_phy, bus.mdio_reg};
                    sl_wd   <= bus.mdio_wdata;
                    sl_cnt  <= sl_dly;
                    sl_st   <= 1;
                end
                1: if (sl_cnt == 0) begin
                    bus.mdio_busy  <= 1'b1;
                    bus.mdio_rdata <= 16'hDEAD;
                    sl_cnt <= sl_len;
                    sl_st  <= 2;
                end else begin
                    sl_cnt <= sl_cnt - 1;
                end
                2: if (sl_cnt == 0) begin
                    bus.mdio_busy <= 1'b0;
                    if (sl_wr) begin
                        phy_mem[sl_addr] <= sl_wd;
                        bus.mdio_rdata   <= 16'd0;
                    end else if (sl_addr == STAT_ADDR) begin
                        bus.mdio_rdata <= stat_val;
                    end else begin
                        bus.mdio_rdata <= phy_mem[sl_addr];
                    end
                    sl_st <= 3;
                end else begin
                    sl_cnt <= sl_cnt - 1;
                end
                3: if (!bus.mdio_start) sl_st <= 0;
                default: sl_st <= 0;
            endcase
        end
    end

    // Observe launches, start pulse lengths, poll spacing and ready pulses.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.mdio_start && !start_prev) begin
            start_cnt <= start_cnt + 1;
            if (!bus.mdio_write && bus.mdio_phy == 5'd0 && bus.mdio_reg == 5'd1) begin
                grant_q.push_back(1'b1);
                poll_start_cnt <= poll_start_cnt + 1;
                poll_period    <= cyc - last_poll_cyc;
                last_poll_cyc  <= cyc;
            end else begin
                grant_q.push_back(1'b0);
            end
        end
        if (bus.mdio_start) begin
            start_run <= start_run + 1;
        end else if (start_prev) begin
            last_start_len <= start_run;
            start_run <= 0;
        end
        start_prev <= bus.mdio_start;
        if (bus.cpu_req_ready) begin
            ready_cnt <= ready_cnt + 1;
            if (ready_prev) ready_dbl <= ready_dbl + 1;
        end
        ready_prev <= bus.cpu_req_ready;
    end

    task automatic cpu_xfer(input logic wr, input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] wd, output logic [15:0] rd, output logic er,
                            output logic ok);
        bus.cpu_req_write = wr;
        bus.cpu_req_phy   = phy;
        bus.cpu_req_reg   = ra;
        bus.cpu_req_wdata = wd;
        bus.cpu_req_valid = 1'b1;
        ok = 1'b0;
        rd = 16'd0;
        er = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.cpu_req_ready) begin
                ok = 1'b1;
                rd = bus.cpu_rsp_rdata;
                er = bus.cpu_rsp_err;
            end
        end
        bus.cpu_req_valid = 1'b0;
    endtask

    task automatic cpu_check(input string tag, input logic wr, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [15:0] wd, input logic exp_err,
                             input logic [15:0] exp_rd, input logic chk_start);
        int s0;
        logic [15:0] rd;
        logic er;
        logic ok;
        s0 = start_cnt;
        cpu_xfer(wr, phy, ra, wd, rd, er, ok);
        chk({tag, "_done"}, ok, 1'b1);
        if (ok) begin
            cpu_n++;
            chk({tag, "_err"}, er, exp_err);
            chk({tag, "_rdata"}, rd, exp_rd);
        end
        if (chk_start) chk({tag, "_starts"}, start_cnt - s0, 1);
    endtask

    task automatic wait_link(input logic val, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.link_up == val) ok = 1'b1;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int a;
        int g0;
        int ncpu;
        int npoll;
        logic wr;
        logic [4:0] phy;
        logic [4:0] ra;
        logic [15:0] wd;

        arst_n = 1'b0;
        slave_rst = 1'b1;
        no_busy = 1'b0;
        sl_dly = 2;
        sl_len = 40;
        stat_val = 16'h796D;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_write = 1'b0;
        bus.cpu_req_phy = 5'd0;
        bus.cpu_req_reg = 5'd0;
        bus.cpu_req_wdata = 16'd0;
        bus.poll_en = 1'b0;
        bus.irq_clr = 1'b0;
        tick(3);
        chk("reset_outputs", outs(), 64'd0);
        arst_n = 1'b1;
        slave_rst = 1'b0;
        tick(2);

        // Basic read of phy 1 reg 2 with a 40-cycle busy
        cpu_check("t1_wr", 1'b1, 5'd1, 5'd2, 16'h0141, 1'b0, 16'd0, 1'b1);
        ref_mem[34] = 16'h0141;
        wr_addrs.push_back(34);
        cpu_check("t1_rd", 1'b0, 5'd1, 5'd2, 16'd0, 1'b0, 16'h0141, 1'b1);

        // Random CPU traffic, poller disabled
        for (int i = 0; i < 20; i++) begin
            sl_dly = $urandom_range(0, 10);
            sl_len = $urandom_range(0, 30);
            if (wr_addrs.size() > 0 && $urandom_range(0, 1) == 1) begin
                a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                phy = 5'(a / 32);
                ra = 5'(a % 32);
                cpu_check($sformatf("rnd%0d_rd", i), 1'b0, phy, ra, 16'h0, 1'b0, ref_mem[a], 1'b1);
            end else begin
                phy = 5'($urandom_range(1, 31));
                ra = 5'($urandom_range(0, 31));
                wd = 16'($urandom);
                a = int'(phy) * 32 + int'(ra);
                cpu_check($sformatf("rnd%0d_wr", i), 1'b1, phy, ra, wd, 1'b0, 16'd0, 1'b1);
                if (!ref_mem.exists(a)) wr_addrs.push_back(a);
                ref_mem[a] = wd;
            end
        end

        // Periodic polling of the status register
        sl_dly = 2;
        sl_len = 8;
        a = poll_start_cnt;
        bus.poll_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (poll_start_cnt >= a + 2) ok = 1'b1;
        end
        chk("t2_polls_seen", ok, 1'b1);
        chk("t2_poll_period", poll_period, POLL_T);
        tick(30);
        chk("t2_link_up", bus.link_up, 1'b1);
        chk("t2_link_status", bus.link_status, 16'h796D);
        chk("t2_link_chg", bus.link_chg, 1'b1);
        bus.irq_clr = 1'b1;
        tick(1);
        bus.irq_clr = 1'b0;
        tick(1);
        chk("t2_chg_cleared", bus.link_chg, 1'b0);
        bus.poll_en = 1'b0;
        tick(40);

        // Back-to-back CPU requests competing with an always-pending poll
        sl_dly = 25;
        sl_len = 40;
        g0 = grant_q.size();
        bus.poll_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = wr_addrs[i % wr_addrs.size()];
            wd = 16'($urandom);
            cpu_check($sformatf("t3_%0d", i), 1'b1, 5'(a / 32), 5'(a % 32), wd, 1'b0, 16'd0, 1'b0);
            ref_mem[a] = wd;
        end
        bus.poll_en = 1'b0;
        tick(100);
        chk("t3_first_grant_cpu", grant_q[g0], 1'b0);
        ncpu = (grant_q[g0] == 1'b0) ? 1 : 0;
        npoll = (grant_q[g0] == 1'b1) ? 1 : 0;
        for (int i = g0 + 1; i < grant_q.size(); i++) begin
            chk($sformatf("t3_alternate_%0d", i - g0), grant_q[i], !grant_q[i-1]);
            if (grant_q[i]) npoll++; else ncpu++;
        end
        chk("t3_cpu_grants", ncpu, 4);
        chk("t3_enough_polls", npoll >= 3, 1'b1);
        chk("t3_link_held", bus.link_up, 1'b1);

        // Timeout with busy never rising: CPU then poll
        sl_dly = 2;
        sl_len = 8;
        no_busy = 1'b1;
        cpu_check("t4_cpu", 1'b0, 5'(wr_addrs[0] / 32), 5'(wr_addrs[0] % 32), 16'd0, 1'b1, 16'hFFFF, 1'b1);
        chk("t4_cpu_start_len", last_start_len, TMO_T);
        bus.poll_en = 1'b1;
        wait_link(1'b0, 400, ok);
        bus.poll_en = 1'b0;
        chk("t4_poll_link_down", ok, 1'b1);
        chk("t4_status_held", bus.link_status, 16'h796D);
        chk("t4_chg_set", bus.link_chg, 1'b1);
        chk("t4_poll_start_len", last_start_len, TMO_T);
        tick(70);
        no_busy = 1'b0;
        bus.irq_clr = 1'b1;
        tick(1);
        bus.irq_clr = 1'b0;
        tick(1);
        chk("t4_chg_cleared", bus.link_chg, 1'b0);

        // Link drop coinciding with irq_clr: the change must survive
        bus.poll_en = 1'b1;
        wait_link(1'b1, 300, ok);
        chk("t5_link_up", ok, 1'b1);
        bus.irq_clr = 1'b1;
        tick(1);
        bus.irq_clr = 1'b0;
        tick(1);
        chk("t5_chg_cleared", bus.link_chg, 1'b0);
        stat_val = 16'h7969;
        bus.irq_clr = 1'b1;
        wait_link(1'b0, 300, ok);
        bus.irq_clr = 1'b0;
        chk("t5_link_down", ok, 1'b1);
        chk("t5_status", bus.link_status, 16'h7969);
        tick(1);
        chk("t5_chg_set_wins", bus.link_chg, 1'b1);
        bus.poll_en = 1'b0;
        tick(60);

        // Asynchronous reset in the middle of a busy phase
        sl_dly = 2;
        sl_len = 40;
        a = wr_addrs[0];
        bus.cpu_req_write = 1'b0;
        bus.cpu_req_phy = 5'(a / 32);
        bus.cpu_req_reg = 5'(a % 32);
        bus.cpu_req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.mdio_busy) ok = 1'b1;
        end
        chk("t6_busy_seen", ok, 1'b1);
        tick(6);
        arst_n = 1'b0;
        slave_rst = 1'b1;
        bus.cpu_req_valid = 1'b0;
        #1;
        chk("t6_async_outputs", outs(), 64'd0);
        tick(3);
        arst_n = 1'b1;
        slave_rst = 1'b0;
        tick(2);
        cpu_check("t6_after", 1'b0, 5'(a / 32), 5'(a % 32), 16'd0, 1'b0, ref_mem[a], 1'b1);

        tick(2);
        chk("ready_single_pulses", ready_dbl, 0);
        chk("ready_pulse_count", ready_cnt, cpu_n);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
